// File: rtl/merge11_pkg.sv
// Shared types and constants for the two-to-one flit merge block.
package merge11_pkg;

    localparam int FLIT_W     = 9;
    localparam int FIFO_DEPTH = 2;

    typedef struct packed {
        logic                tail;
        logic [FLIT_W-2:0]   payload;
    } flit_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/merge11_fifo2.sv
// Two-entry FIFO holding {sel, flit}; caller only pushes when not full.
module merge11_fifo2
    import merge11_pkg::*;
#(
    parameter int DW = FLIT_W + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    output logic          full,
    output logic          head_valid,
    output logic [DW-1:0] head_data,
    input  logic          pop_ready
);

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic          pop;

    assign pop        = head_valid & pop_ready;
    assign full       = (count == 2'(FIFO_DEPTH));
    assign head_valid = (count != 2'd0);
    assign head_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/merge11_sync.sv
// Merges two flit streams into one with packet-level locking and round-robin
// arbitration; each output flit carries the index of its source on out_sel.
module merge11_sync
    import merge11_pkg::*;
#(
    parameter int W = FLIT_W
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [W-1:0] in0_data,
    input  logic         in0_valid,
    output logic         in0_ready,
    input  logic [W-1:0] in1_data,
    input  logic         in1_valid,
    output logic         in1_ready,
    output logic [W-1:0] out_data,
    output logic         out_sel,
    output logic         out_valid,
    input  logic         out_ready,
    output arb_state_e   arb_state
);

    // Handshake: a flit moves on any channel exactly when valid and ready are
    // both high at a rising CLK edge; ready never depends on out_ready.

    arb_state_e state, state_next;
    logic       rr, rr_next;
    logic       grant0, grant1;
    logic       acc0, acc1;
    logic       fifo_full, fifo_valid;
    logic [W:0] fifo_head;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ARB_IDLE;
            rr    <= 1'b0;
        end else begin
            state <= state_next;
            rr    <= rr_next;
        end
    end

    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        state_next = state;
        rr_next    = rr;
        unique case (state)
            ARB_IDLE: begin
                if (in0_valid && (!in1_valid || !rr)) grant0 = 1'b1;
                else if (in1_valid)                   grant1 = 1'b1;
            end
            ARB_LOCK0: grant0 = 1'b1;
            ARB_LOCK1: grant1 = 1'b1;
            default: ;
        endcase
        // Any tail ends the packet and hands priority to the other source.
        if (acc0) begin
            if (in0_data[W-1]) begin
                state_next = ARB_IDLE;
                rr_next    = 1'b1;
            end else begin
                state_next = ARB_LOCK0;
            end
        end else if (acc1) begin
            if (in1_data[W-1]) begin
                state_next = ARB_IDLE;
                rr_next    = 1'b0;
            end else begin
                state_next = ARB_LOCK1;
            end
        end
    end

    assign in0_ready = grant0 & ~fifo_full & ~RESET;
    assign in1_ready = grant1 & ~fifo_full & ~RESET;
    assign acc0      = in0_valid & in0_ready;
    assign acc1      = in1_valid & in1_ready;

    merge11_fifo2 #(.DW(W + 1)) u_fifo (
        .clk        (CLK),
        .reset      (RESET),
        .push       (acc0 | acc1),
        .push_data  ({acc1, (acc1 ? in1_data : in0_data)}),
        .full       (fifo_full),
        .head_valid (fifo_valid),
        .head_data  (fifo_head),
        .pop_ready  (out_ready)
    );

    assign out_valid = fifo_valid & ~RESET;
    assign out_sel   = fifo_head[W];
    assign out_data  = fifo_head[W-1:0];
    assign arb_state = state;

endmodule
